// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity-mode codes, latched frame
// configuration and the parity helper used by both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam logic [1:0] PAR_ODD   = 2'b11;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b01;
  localparam logic [1:0] PAR_SPACE = 2'b00;

  typedef struct packed {
    logic [7:0] data;
    logic       data_size;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic       stop_bit_size;
  } uart_frame_t;

  // data[7] only participates when the frame carries 8 data bits
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic       data_size,
                                      input logic [1:0] mode);
    logic x;
    logic p;
    x = data_size ? ^data : ^data[6:0];
    case (mode)
      PAR_ODD:  p = ~x;
      PAR_EVEN: p = x;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] last_data_idx(input logic data_size);
    return data_size ? 3'd7 : 3'd6;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side request bus of the UART transmitter: frame data, frame
// configuration and the send/ready/done handshake.
interface uart_tx_if;
  logic [7:0] data;
  logic       data_size;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic       stop_bit_size;
  logic       send;
  logic       ready;
  logic       done;

  modport master (
    output data, data_size, parity_en, parity_mode, stop_bit_size, send,
    input  ready, done
  );

  modport slave (
    input  data, data_size, parity_en, parity_mode, stop_bit_size, send,
    output ready, done
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// One-entry holding register for a frame requested while the line is busy;
// push and pop never coincide because push is only possible while empty.
module uart_tx_buffer
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  uart_frame_t push_frame,
  input  logic        pop,
  output logic        full,
  output uart_frame_t frame
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      full  <= 1'b0;
      frame <= '0;
    end else if (push) begin
      full  <= 1'b1;
      frame <= push_frame;
    end else if (pop) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 7/8 LSB-first data bits, optional parity, 1/2 stop bits,
// one bit per active uartClock edge. UART_TX_BUFFER_EN adds a one-frame holding buffer.
module uart_tx
  import uart_pkg::*;
#(
  parameter bit CLK_EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uartClock,
  output logic       tx,
  output logic       uartEn,
  uart_tx_if.slave   host
);

  uart_state_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  uart_frame_t frame_q, frame_d;
  uart_frame_t in_frame;
  logic        tx_q, tx_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        uclk_q;
  logic        active_edge;
  logic        ready_int;
  logic        accept;

`ifdef UART_TX_BUFFER_EN
  logic        buf_full;
  logic        buf_push;
  logic        buf_pop;
  logic        direct_start;
  uart_frame_t buf_frame;

  uart_tx_buffer u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_push),
    .push_frame (in_frame),
    .pop        (buf_pop),
    .full       (buf_full),
    .frame      (buf_frame)
  );

  assign ready_int = ~buf_full;
`else
  assign ready_int = (state_q == ST_IDLE);
`endif

  assign accept = host.send & ready_int;

  // Edges are only meaningful while our own enable keeps the baud generator running
  assign active_edge = en_q && (uartClock == CLK_EDGE) && (uclk_q != CLK_EDGE);

  always_comb begin
    in_frame               = '0;
    in_frame.data          = host.data;
    in_frame.data_size     = host.data_size;
    in_frame.parity_en     = host.parity_en;
    in_frame.parity_mode   = host.parity_mode;
    in_frame.stop_bit_size = host.stop_bit_size;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    tx_d      = tx_q;
    en_d      = en_q;
    done_d    = 1'b0;
`ifdef UART_TX_BUFFER_EN
    buf_pop      = 1'b0;
    direct_start = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d   = in_frame;
          state_d   = ST_START;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b0;
          en_d      = 1'b1;
`ifdef UART_TX_BUFFER_EN
          direct_start = 1'b1;
`endif
        end
      end

      ST_START: begin
        if (active_edge) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = frame_q.data[0];
        end
      end

      ST_DATA: begin
        if (active_edge) begin
          if (bit_cnt_q == last_data_idx(frame_q.data_size)) begin
            bit_cnt_d = 3'd0;
            if (frame_q.parity_en) begin
              state_d = ST_PARITY;
              tx_d    = parity_bit(frame_q.data, frame_q.data_size, frame_q.parity_mode);
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = frame_q.data[bit_cnt_q + 3'd1];
          end
        end
      end

      ST_PARITY: begin
        if (active_edge) begin
          state_d   = ST_STOP;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b1;
        end
      end

      ST_STOP: begin
        if (active_edge) begin
          if (frame_q.stop_bit_size && (bit_cnt_q == 3'd0)) begin
            bit_cnt_d = 3'd1;
          end else begin
            done_d    = 1'b1;
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            tx_d      = 1'b1;
            en_d      = 1'b0;
`ifdef UART_TX_BUFFER_EN
            // Chain the next frame without an idle gap; a send arriving on
            // this very cycle goes straight to the line instead of the buffer.
            if (buf_full) begin
              frame_d = buf_frame;
              buf_pop = 1'b1;
              state_d = ST_START;
              tx_d    = 1'b0;
              en_d    = 1'b1;
            end else if (accept) begin
              frame_d      = in_frame;
              direct_start = 1'b1;
              state_d      = ST_START;
              tx_d         = 1'b0;
              en_d         = 1'b1;
            end
`endif
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
        tx_d      = 1'b1;
        en_d      = 1'b0;
      end
    endcase
  end

`ifdef UART_TX_BUFFER_EN
  assign buf_push = accept & ~direct_start;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      frame_q   <= '0;
      tx_q      <= 1'b1;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      uclk_q    <= CLK_EDGE;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      tx_q      <= tx_d;
      en_q      <= en_d;
      done_q    <= done_d;
      uclk_q    <= uartClock;
    end
  end

  assign tx         = tx_q;
  assign uartEn     = en_q;
  assign host.ready = ready_int;
  assign host.done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame table, mid-frame send/config changes,
// reset abort, and randomized frames checked against a bit-list model.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_clock = 1'b0;
  logic tx;
  logic uart_en;

  uart_tx_if host();

  uart_tx #(.CLK_EDGE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .uartClock (uart_clock),
    .tx        (tx),
    .uartEn    (uart_en),
    .host      (host)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       data_size;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic       stop_two;
  } cfg_t;

  typedef struct {
    cfg_t        c;
    logic [11:0] bits;   // leftmost of the len used bits is the first bit period
    int          len;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int en_falls = 0;
  int baud_cnt = 0;
  bit prev_en  = 1'b0;
  bit buf_mode = 1'b0;
  bit cap_q[$];
  bit exp_q[$];

  // Free-running baud clock (8 clk per bit); the line value is captured just
  // before each rising edge the transmitter is listening to.
  always @(negedge clk) begin
    if (baud_cnt == 3) begin
      baud_cnt = 0;
      if (!uart_clock && uart_en === 1'b1) cap_q.push_back(tx);
      uart_clock = ~uart_clock;
    end else begin
      baud_cnt++;
    end
    if (host.done === 1'b1) done_cnt++;
    if (prev_en && uart_en === 1'b0) en_falls++;
    prev_en = (uart_en === 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic void model(input cfg_t c);
    int n;
    int ones;
    bit p;
    n    = c.data_size ? 8 : 7;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(c.data[i]);
      if (c.data[i]) ones++;
    end
    if (c.parity_en) begin
      case (c.parity_mode)
        2'b11:   p = (ones % 2 == 0);
        2'b10:   p = (ones % 2 == 1);
        2'b01:   p = 1'b1;
        default: p = 1'b0;
      endcase
      exp_q.push_back(p);
    end
    exp_q.push_back(1'b1);
    if (c.stop_two) exp_q.push_back(1'b1);
  endfunction

  function automatic logic [63:0] pack_cap();
    logic [63:0] v = '0;
    for (int i = 0; i < cap_q.size() && i < 64; i++) v[i] = cap_q[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_exp();
    logic [63:0] v = '0;
    for (int i = 0; i < exp_q.size() && i < 64; i++) v[i] = exp_q[i];
    return v;
  endfunction

  task automatic compare_stream(input string name);
    chk({name, "_len"}, 64'(cap_q.size()), 64'(exp_q.size()));
    chk({name, "_bits"}, pack_cap(), pack_exp());
  endtask

  task automatic drive(input cfg_t c);
    host.data          = c.data;
    host.data_size     = c.data_size;
    host.parity_en     = c.parity_en;
    host.parity_mode   = c.parity_mode;
    host.stop_bit_size = c.stop_two;
    host.send          = 1'b1;
    tick();
    host.send          = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 600) begin
      tick();
      k++;
    end
    if (done_cnt < target) chk({name, "_done_timeout"}, 64'(done_cnt), 64'(target));
  endtask

  task automatic run_frame(input cfg_t c, input string name);
    int d0;
    cap_q.delete();
    exp_q.delete();
    model(c);
    d0 = done_cnt;
    chk({name, "_ready_pre"}, 64'(host.ready), 64'd1);
    drive(c);
    wait_done(d0 + 1, name);
    tick();
    tick();
    compare_stream(name);
    chk({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_en_low"}, 64'(uart_en), 64'd0);
    chk({name, "_ready_post"}, 64'(host.ready), 64'd1);
    chk({name, "_tx_idle"}, 64'(tx), 64'd1);
  endtask

  vec_t vt[6];
  cfg_t ca, cb, cc, cr;
  logic [63:0] tv;
  int d0, e0, k;

  initial begin
`ifdef UART_TX_BUFFER_EN
    buf_mode = 1'b1;
`endif
    host.data = '0; host.data_size = 1'b1; host.parity_en = 1'b0;
    host.parity_mode = 2'b00; host.stop_bit_size = 1'b0; host.send = 1'b0;

    vt[0] = '{c: '{8'h95, 1'b1, 1'b1, 2'b01, 1'b0}, bits: 12'b0_01010100111, len: 11};
    vt[1] = '{c: '{8'h95, 1'b1, 1'b1, 2'b11, 1'b0}, bits: 12'b0_01010100111, len: 11};
    vt[2] = '{c: '{8'h95, 1'b1, 1'b1, 2'b10, 1'b0}, bits: 12'b0_01010100101, len: 11};
    vt[3] = '{c: '{8'h95, 1'b0, 1'b1, 2'b10, 1'b0}, bits: 12'b00_0101010011, len: 10};
    vt[4] = '{c: '{8'h95, 1'b1, 1'b0, 2'b00, 1'b1}, bits: 12'b0_01010100111, len: 11};
    vt[5] = '{c: '{8'h95, 1'b0, 1'b1, 2'b00, 1'b1}, bits: 12'b0_01010100011, len: 11};

    tick();
    tick();
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_en", 64'(uart_en), 64'd0);
    chk("rst_ready", 64'(host.ready), 64'd1);
    chk("rst_done", 64'(host.done), 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i].c, $sformatf("vec%0d", i));
      tv = '0;
      for (int j = 0; j < vt[i].len; j++) tv[j] = vt[i].bits[vt[i].len - 1 - j];
      chk($sformatf("vec%0d_table", i), pack_cap(), tv);
    end

    // Second request and config churn while a frame is on the line
    ca = '{8'h95, 1'b1, 1'b1, 2'b01, 1'b0};
    cb = '{8'h3C, 1'b0, 1'b1, 2'b11, 1'b1};
    cap_q.delete();
    exp_q.delete();
    model(ca);
    if (buf_mode) model(cb);
    d0 = done_cnt;
    e0 = en_falls;
    drive(ca);
    repeat (20) tick();
    chk("mid_ready_busy", 64'(host.ready), 64'(buf_mode));
    host.data = cb.data; host.data_size = cb.data_size; host.parity_en = cb.parity_en;
    host.parity_mode = cb.parity_mode; host.stop_bit_size = cb.stop_two;
    host.send = 1'b1;
    tick();
    host.send = 1'b0;
    chk("mid_ready_after", 64'(host.ready), 64'd0);
    for (int i = 0; i < 6; i++) begin
      host.data = 8'($urandom);
      host.parity_mode = 2'($urandom);
      host.data_size = 1'($urandom);
      host.parity_en = 1'($urandom);
      host.stop_bit_size = 1'($urandom);
      tick();
    end
    wait_done(d0 + (buf_mode ? 2 : 1), "mid");
    repeat (60) tick();
    compare_stream("mid");
    chk("mid_done_cnt", 64'(done_cnt - d0), 64'(buf_mode ? 2 : 1));
    chk("mid_en_falls", 64'(en_falls - e0), 64'd1);

    // Reset in the middle of data bit 3
    cc = '{8'hA7, 1'b1, 1'b1, 2'b10, 1'b0};
    cap_q.delete();
    d0 = done_cnt;
    drive(cc);
    k = 0;
    while (cap_q.size() < 4 && k < 200) begin
      tick();
      k++;
    end
    if (cap_q.size() < 4) chk("rstmid_timeout", 64'(cap_q.size()), 64'd4);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_tx", 64'(tx), 64'd1);
    chk("rstmid_en", 64'(uart_en), 64'd0);
    chk("rstmid_ready", 64'(host.ready), 64'd1);
    rst = 1'b1;
    repeat (20) tick();
    chk("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame('{8'h5A, 1'b1, 1'b1, 2'b11, 1'b1}, "post_rst");

    for (int i = 0; i < 16; i++) begin
      cr.data        = 8'($urandom);
      cr.data_size   = 1'($urandom);
      cr.parity_en   = 1'($urandom);
      cr.parity_mode = 2'($urandom_range(0, 3));
      cr.stop_two    = 1'($urandom);
      run_frame(cr, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
